axi_crossbar_addr_admit: RTL
============================

# axi_crossbar_addr_admit

Per-slave-port address decode and admission control stage for the AXI4 crossbar, next generation. Sits between each crossbar slave interface and the address-channel arbiters. It decodes AW/AR addresses to a master port and region, and generates decode errors. On top of the global accept limit and ID-thread ordering, it adds a per-destination outstanding-issue limit, with completions resolved to their destination through the thread table.

## Interface
- S, 0, slave interface index
- S_COUNT, 4, number of slave interfaces
- M_COUNT, 4, number of master interfaces
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 8, ID width
- S_THREADS, 4, concurrent unique IDs; clamped to S_ACCEPT
- S_ACCEPT, 16, max outstanding transactions from this slave
- M_ISSUE, 8, max outstanding transactions from this slave to any one master port; must satisfy 1..S_ACCEPT
- M_REGIONS, 1, regions per master
- M_BASE_ADDR, 0, M_COUNT×M_REGIONS×ADDR_WIDTH bases; 0 means auto-packed, aligned bases
- M_ADDR_WIDTH, 24 per region, 32-bit fields; 0 disables the region; otherwise 12..ADDR_WIDTH
- M_CONNECT, all ones, M_COUNT×S_COUNT connectivity bits
- M_SECURE, 0, per-master bit; when set, requests with aprot[1]=1 fail decode
- WC_OUTPUT, 0, enable the write-command output

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- s_axi_aid  in  ID_WIDTH  request ID
- s_axi_aaddr  in  ADDR_WIDTH  request address
- s_axi_aprot  in  3  protection bits
- s_axi_avalid / s_axi_aready  in / out  1  request handshake
- m_axi_aregion  out  4  decoded region
- m_select  out  clog2(M_COUNT)  decoded master
- m_axi_avalid / m_axi_aready  out / in  1  forward handshake
- m_wc_select, m_wc_decerr, m_wc_valid / m_wc_ready  out / in  write-command channel
- m_rc_decerr, m_rc_valid / m_rc_ready  out / in  reply-command channel; used for decode errors only
- s_cpl_id, s_cpl_valid  in  ID_WIDTH, 1  completion report, one per cycle
- outstanding  out  clog2(S_ACCEPT+1)  current global outstanding count

## Operation
- States: IDLE, DECODE.
- IDLE, with s_axi_avalid=1 and s_axi_aready=0: decode the address. A region matches when its width is nonzero, it is connected to S, the secure check passes, and addr>>width equals base>>width. Regions are non-overlapping, so at most one hits.
- On a hit, the request is admitted only when all three hold:
  - the global count is below S_ACCEPT, or a completion arrives this cycle;
  - the destination count is below M_ISSUE, or a completion for that destination arrives this cycle;
  - either an active thread with the same ID targets the same master and region, or no thread carries this ID and a free thread exists.
- Admit: register select and region; set m_axi_avalid=1, m_wc_valid=WC_OUTPUT, decerr=0; allocate the lowest-index free thread, or reuse the matching thread. Increment the thread, global and destination counts. Go to DECODE.
- Hit but refused: hold in IDLE; the request is not consumed.
- Miss: set decerr=1, m_axi_avalid=0, m_rc_valid=1, m_wc_valid=WC_OUTPUT; no counts change. Go to DECODE.
- DECODE: each valid drops on its own ready. Once every valid is low, pulse s_axi_aready for one cycle and return to IDLE.
- Completion: s_cpl_id matching an active thread decrements that thread's count, the global count, and the count of the thread's stored destination. A completion with no matching thread is ignored.
- Start and completion on the same thread in the same cycle leave all counts unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0, all threads free. Reset mid-transaction discards all outstanding state.
- Request to m_axi_avalid: 1 cycle.
- m_axi_aready handshake to s_axi_aready: 1 cycle. Minimum spacing between accepted requests is 3 cycles.
- m_select and m_axi_aregion stay stable while any output valid is high.

## Configuration
- AXI_XBAR_ADDR_STALL_CNT_EN defined: adds output port stall_count[31:0], reset to 0.
  - Increments on each cycle in IDLE with a decode hit refused by admission.
  - Saturates at 0xFFFFFFFF.
- Not defined: the port and the counter are absent; behaviour is otherwise identical.

## Test plan
- M_COUNT=2, default widths, addr 0x0100_0040, id 3, ready always high → m_select=1, region 0, m_axi_avalid in cycle 1, s_axi_aready in cycle 2, outstanding=1.
- addr 0xFF00_0000 → m_rc_valid=1 with m_rc_decerr=1, m_axi_avalid never asserts, outstanding stays 0.
- M_ISSUE=2: three requests to master 0 with distinct IDs, no completions → third held (s_axi_aready low); a completion for one ID releases it the same cycle.
- Id 5 outstanding to master 0, new id 5 request to master 1 → blocked until id 5 completes, then admitted.
- S_THREADS=2: ids 1 and 2 active, id 3 request → blocked; a start and a completion on id 1 in the same cycle → id 1 count unchanged.
- rst_n asserted with outstanding=4 → all outputs and counts 0 asynchronously; a later completion for a stale ID is ignored.

Source files
------------

// File: rtl/axi_crossbar_addr_admit.sv
// axi_crossbar_addr_admit
// Address decode and admission control for one crossbar slave interface.
// Decodes AW/AR addresses to a master port and region, raises decode
// errors, and limits outstanding work globally, per destination master and
// per ID thread, so that responses for one ID stay in order.
// Optional feature: define AXI_XBAR_ADDR_STALL_CNT_EN to add the stall_count
// output. It counts cycles where a decoded request was refused admission.
module axi_crossbar_addr_admit #(
    parameter int S          = 0,
    parameter int S_COUNT    = 4,
    parameter int M_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int S_THREADS  = 4,
    parameter int S_ACCEPT   = 16,
    parameter int M_ISSUE    = 8,
    parameter int M_REGIONS  = 1,
    parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
    parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH = {M_COUNT*M_REGIONS{32'd24}},
    parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = {M_COUNT*S_COUNT{1'b1}},
    parameter logic [M_COUNT-1:0] M_SECURE = '0,
    parameter int WC_OUTPUT  = 0,
    localparam int SEL_W     = (M_COUNT > 1) ? $clog2(M_COUNT) : 1,
    localparam int CNT_W     = $clog2(S_ACCEPT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_aid,
    input  logic [ADDR_WIDTH-1:0] s_axi_aaddr,
    input  logic [2:0]            s_axi_aprot,
    input  logic                  s_axi_avalid,
    output logic                  s_axi_aready,
    output logic [3:0]            m_axi_aregion,
    output logic [SEL_W-1:0]      m_select,
    output logic                  m_axi_avalid,
    input  logic                  m_axi_aready,
    output logic [SEL_W-1:0]      m_wc_select,
    output logic                  m_wc_decerr,
    output logic                  m_wc_valid,
    input  logic                  m_wc_ready,
    output logic                  m_rc_decerr,
    output logic                  m_rc_valid,
    input  logic                  m_rc_ready,
    input  logic [ID_WIDTH-1:0]   s_cpl_id,
    input  logic                  s_cpl_valid,
    output logic [CNT_W-1:0]      outstanding
`ifdef AXI_XBAR_ADDR_STALL_CNT_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    localparam int THREADS      = (S_THREADS < S_ACCEPT) ? S_THREADS : S_ACCEPT;
    localparam int TID_W        = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int DST_W        = $clog2(M_ISSUE + 1);
    localparam int REGION_COUNT = M_COUNT * M_REGIONS;
    localparam logic [CNT_W-1:0] ACCEPT_MAX = CNT_W'(S_ACCEPT);
    localparam logic [DST_W-1:0] ISSUE_MAX  = DST_W'(M_ISSUE);
    localparam logic WC_EN = (WC_OUTPUT != 0);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_DECODE = 1'b1;

    // Pack enabled regions back to back, each aligned to its own size.
    function automatic logic [REGION_COUNT*ADDR_WIDTH-1:0] calc_base_addrs();
        logic [REGION_COUNT*ADDR_WIDTH-1:0] bases;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] size;
        int width;
        bases = '0;
        base  = '0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            width = int'(M_ADDR_WIDTH[i*32 +: 32]);
            if (width > 0) begin
                mask = {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - width);
                size = mask + ADDR_WIDTH'(1);
                if ((base & mask) != '0) begin
                    base = base + size - (base & mask);
                end
                bases[i*ADDR_WIDTH +: ADDR_WIDTH] = base;
                base = base + size;
            end
        end
        return bases;
    endfunction

    localparam logic [REGION_COUNT*ADDR_WIDTH-1:0] BASE_ADDRS =
        (M_BASE_ADDR == '0) ? calc_base_addrs() : M_BASE_ADDR;

    // Control and output flops.
    logic [0:0]       state_q, state_d;
    logic             s_axi_aready_q, s_axi_aready_d;
    logic             m_axi_avalid_q, m_axi_avalid_d;
    logic             m_wc_valid_q, m_wc_valid_d;
    logic             m_rc_valid_q, m_rc_valid_d;
    logic             decerr_q, decerr_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic [3:0]       region_q, region_d;

    // Thread table and counters.
    logic [ID_WIDTH-1:0] thr_id_q     [THREADS];
    logic [ID_WIDTH-1:0] thr_id_d     [THREADS];
    logic [SEL_W-1:0]    thr_sel_q    [THREADS];
    logic [SEL_W-1:0]    thr_sel_d    [THREADS];
    logic [3:0]          thr_region_q [THREADS];
    logic [3:0]          thr_region_d [THREADS];
    logic [CNT_W-1:0]    thr_cnt_q    [THREADS];
    logic [CNT_W-1:0]    thr_cnt_d    [THREADS];
    logic [DST_W-1:0]    dst_cnt_q    [M_COUNT];
    logic [DST_W-1:0]    dst_cnt_d    [M_COUNT];
    logic [CNT_W-1:0]    glob_cnt_q, glob_cnt_d;

    // Decode and admission terms.
    logic             dec_hit;
    logic [SEL_W-1:0] dec_sel;
    logic [3:0]       dec_region;
    logic             id_match;
    logic [TID_W-1:0] id_thread;
    logic             free_found;
    logic [TID_W-1:0] free_thread;
    logic             cpl_match;
    logic [TID_W-1:0] cpl_thread;
    logic [SEL_W-1:0] cpl_sel;
    logic             req_active;
    logic             global_ok;
    logic             dest_ok;
    logic             thread_ok;
    logic             start;
    logic [TID_W-1:0] start_thread;

    // Only aprot[1] (non-secure) takes part in the decode.
    logic unused_prot;
    assign unused_prot = s_axi_aprot[0] ^ s_axi_aprot[2];

    // Address decode: find the single enabled, connected, permitted region containing the address.
    always_comb begin
        dec_hit    = 1'b0;
        dec_sel    = '0;
        dec_region = '0;
        for (int m = 0; m < M_COUNT; m++) begin
            for (int r = 0; r < M_REGIONS; r++) begin
                if ((M_ADDR_WIDTH[(m*M_REGIONS+r)*32 +: 32] != 32'd0)
                    && M_CONNECT[m*S_COUNT+S]
                    && !(M_SECURE[m] && s_axi_aprot[1])
                    && ((s_axi_aaddr >> M_ADDR_WIDTH[(m*M_REGIONS+r)*32 +: 32]) ==
                        (BASE_ADDRS[(m*M_REGIONS+r)*ADDR_WIDTH +: ADDR_WIDTH]
                            >> M_ADDR_WIDTH[(m*M_REGIONS+r)*32 +: 32]))) begin
                    dec_hit    = 1'b1;
                    dec_sel    = SEL_W'(m);
                    dec_region = 4'(r);
                end
            end
        end
    end

    // Thread lookup: same-ID thread, lowest free thread, and the thread a completion retires.
    always_comb begin
        id_match    = 1'b0;
        id_thread   = '0;
        free_found  = 1'b0;
        free_thread = '0;
        cpl_match   = 1'b0;
        cpl_thread  = '0;
        for (int t = THREADS - 1; t >= 0; t--) begin
            if (thr_cnt_q[t] == '0) begin
                free_found  = 1'b1;
                free_thread = TID_W'(t);
            end
            if ((thr_cnt_q[t] != '0) && (thr_id_q[t] == s_axi_aid)) begin
                id_match  = 1'b1;
                id_thread = TID_W'(t);
            end
            if ((thr_cnt_q[t] != '0) && s_cpl_valid && (thr_id_q[t] == s_cpl_id)) begin
                cpl_match  = 1'b1;
                cpl_thread = TID_W'(t);
            end
        end
        cpl_sel = thr_sel_q[cpl_thread];
    end

    // Admission: a same-cycle completion frees the capacity it retires.
    always_comb begin
        req_active = (state_q == ST_IDLE) && s_axi_avalid && !s_axi_aready_q;
        global_ok  = (glob_cnt_q < ACCEPT_MAX) || cpl_match;
        dest_ok    = (dst_cnt_q[dec_sel] < ISSUE_MAX) || (cpl_match && (cpl_sel == dec_sel));
        if (id_match) begin
            thread_ok = (thr_sel_q[id_thread] == dec_sel) && (thr_region_q[id_thread] == dec_region);
        end else begin
            thread_ok = free_found;
        end
        start        = req_active && dec_hit && global_ok && dest_ok && thread_ok;
        start_thread = id_match ? id_thread : free_thread;
    end

    // Counter and thread-table update; a start and a completion on the same counter cancel.
    always_comb begin
        glob_cnt_d = glob_cnt_q;
        if (start && !cpl_match) begin
            glob_cnt_d = glob_cnt_q + CNT_W'(1);
        end else if (!start && cpl_match) begin
            glob_cnt_d = glob_cnt_q - CNT_W'(1);
        end
        for (int t = 0; t < THREADS; t++) begin
            thr_id_d[t]     = thr_id_q[t];
            thr_sel_d[t]    = thr_sel_q[t];
            thr_region_d[t] = thr_region_q[t];
            thr_cnt_d[t]    = thr_cnt_q[t];
            if (start && (start_thread == TID_W'(t))) begin
                thr_id_d[t]     = s_axi_aid;
                thr_sel_d[t]    = dec_sel;
                thr_region_d[t] = dec_region;
            end
            if ((start && (start_thread == TID_W'(t))) && !(cpl_match && (cpl_thread == TID_W'(t)))) begin
                thr_cnt_d[t] = thr_cnt_q[t] + CNT_W'(1);
            end else if (!(start && (start_thread == TID_W'(t))) && (cpl_match && (cpl_thread == TID_W'(t)))) begin
                thr_cnt_d[t] = thr_cnt_q[t] - CNT_W'(1);
            end
        end
        for (int m = 0; m < M_COUNT; m++) begin
            dst_cnt_d[m] = dst_cnt_q[m];
            if ((start && (dec_sel == SEL_W'(m))) && !(cpl_match && (cpl_sel == SEL_W'(m)))) begin
                dst_cnt_d[m] = dst_cnt_q[m] + DST_W'(1);
            end else if (!(start && (dec_sel == SEL_W'(m))) && (cpl_match && (cpl_sel == SEL_W'(m)))) begin
                dst_cnt_d[m] = dst_cnt_q[m] - DST_W'(1);
            end
        end
    end

    // Handshake sequencing: launch forward/error commands, then acknowledge the slave once all drain.
    always_comb begin
        state_d        = state_q;
        s_axi_aready_d = 1'b0;
        m_axi_avalid_d = m_axi_avalid_q;
        m_wc_valid_d   = m_wc_valid_q;
        m_rc_valid_d   = m_rc_valid_q;
        decerr_d       = decerr_q;
        select_d       = select_q;
        region_d       = region_q;
        case (state_q)
            ST_IDLE: begin
                if (req_active) begin
                    if (!dec_hit) begin
                        decerr_d       = 1'b1;
                        m_axi_avalid_d = 1'b0;
                        m_rc_valid_d   = 1'b1;
                        m_wc_valid_d   = WC_EN;
                        state_d        = ST_DECODE;
                    end else if (start) begin
                        select_d       = dec_sel;
                        region_d       = dec_region;
                        decerr_d       = 1'b0;
                        m_axi_avalid_d = 1'b1;
                        m_rc_valid_d   = 1'b0;
                        m_wc_valid_d   = WC_EN;
                        state_d        = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                m_axi_avalid_d = m_axi_avalid_q && !m_axi_aready;
                m_wc_valid_d   = m_wc_valid_q && !m_wc_ready;
                m_rc_valid_d   = m_rc_valid_q && !m_rc_ready;
                if (!m_axi_avalid_d && !m_wc_valid_d && !m_rc_valid_d) begin
                    s_axi_aready_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards every outstanding transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            s_axi_aready_q <= 1'b0;
            m_axi_avalid_q <= 1'b0;
            m_wc_valid_q   <= 1'b0;
            m_rc_valid_q   <= 1'b0;
            decerr_q       <= 1'b0;
            select_q       <= '0;
            region_q       <= '0;
            glob_cnt_q     <= '0;
            for (int t = 0; t < THREADS; t++) begin
                thr_id_q[t]     <= '0;
                thr_sel_q[t]    <= '0;
                thr_region_q[t] <= '0;
                thr_cnt_q[t]    <= '0;
            end
            for (int m = 0; m < M_COUNT; m++) begin
                dst_cnt_q[m] <= '0;
            end
        end else begin
            state_q        <= state_d;
            s_axi_aready_q <= s_axi_aready_d;
            m_axi_avalid_q <= m_axi_avalid_d;
            m_wc_valid_q   <= m_wc_valid_d;
            m_rc_valid_q   <= m_rc_valid_d;
            decerr_q       <= decerr_d;
            select_q       <= select_d;
            region_q       <= region_d;
            glob_cnt_q     <= glob_cnt_d;
            for (int t = 0; t < THREADS; t++) begin
                thr_id_q[t]     <= thr_id_d[t];
                thr_sel_q[t]    <= thr_sel_d[t];
                thr_region_q[t] <= thr_region_d[t];
                thr_cnt_q[t]    <= thr_cnt_d[t];
            end
            for (int m = 0; m < M_COUNT; m++) begin
                dst_cnt_q[m] <= dst_cnt_d[m];
            end
        end
    end

`ifdef AXI_XBAR_ADDR_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a decoded request was refused admission.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (req_active && dec_hit && !start && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

    assign s_axi_aready  = s_axi_aready_q;
    assign m_axi_avalid  = m_axi_avalid_q;
    assign m_axi_aregion = region_q;
    assign m_select      = select_q;
    assign m_wc_select   = select_q;
    assign m_wc_decerr   = decerr_q;
    assign m_wc_valid    = m_wc_valid_q;
    assign m_rc_decerr   = decerr_q;
    assign m_rc_valid    = m_rc_valid_q;
    assign outstanding   = glob_cnt_q;

endmodule
